// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants for the multi-port register file and decode.
//  Revision    : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_clear_seq.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_clear_seq
//  Description : Soft-clear sequencer; sweeps every entry once after a Clear.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clear) begin
                        r_state <= ST_CLEAR;
                        r_cnt   <= '0;
                    end
                end
                ST_CLEAR: begin
                    // Counter wraps to 0 on the last entry, ready for the next sweep.
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == {ADDR_W{1'b1}}) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy     = (r_state == ST_CLEAR);
    assign clr_we   = (r_state == ST_CLEAR);
    assign clr_addr = r_cnt;

endmodule : regfile_clear_seq
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_mp
//  Description : 2R/2W register file with bypass, zero register and soft clear.
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clock,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] ReadAddr1,
    input  logic [ADDR_W-1:0] ReadAddr2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              WriteEn0,
    input  logic [ADDR_W-1:0] WriteAddr0,
    input  logic [DATA_W-1:0] WriteData0,
    input  logic              WriteEn1,
    input  logic [ADDR_W-1:0] WriteAddr1,
    input  logic [DATA_W-1:0] WriteData1,
    input  logic              Clear,
    output logic              Busy
);

    localparam int c_DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_we0_ok;
    logic              w_we1_ok;

    regfile_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk      (clock),
        .rst_n    (Reset_n),
        .clear    (Clear),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign Busy = w_busy;

    // Port 1 owns a shared address, so port 0 is masked rather than relying on NBA order.
    assign w_we1_ok = WriteEn1 && !((ZERO_REG != 0) && (WriteAddr1 == '0));
    assign w_we0_ok = WriteEn0 && !((ZERO_REG != 0) && (WriteAddr0 == '0))
                      && !(WriteEn1 && (WriteAddr1 == WriteAddr0));

    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            if (w_we0_ok) r_mem[WriteAddr0] <= WriteData0;
            if (w_we1_ok) r_mem[WriteAddr1] <= WriteData1;
        end
    end

    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = r_mem[addr];
        if ((BYPASS != 0) && !w_busy) begin
            if (WriteEn0 && (WriteAddr0 == addr)) v = WriteData0;
            if (WriteEn1 && (WriteAddr1 == addr)) v = WriteData1;
        end
        if ((ZERO_REG != 0) && (addr == '0)) v = '0;
        return v;
    endfunction

    always_comb begin
        ReadData1 = f_read(ReadAddr1);
        ReadData2 = f_read(ReadAddr2);
    end

endmodule : regfile_mp
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_mp
//  Description : Directed bench for regfile_mp, bypass-on and bypass-off builds.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra1, ra2;
    logic        we0, we1;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        clear;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        busy_b, busy_n;

    int n_vec = 0;
    int n_err = 0;
    int cycles;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(1), .ZERO_REG(1)) u_dut_byp (
        .clock(clk), .Reset_n(rst_n),
        .ReadAddr1(ra1), .ReadAddr2(ra2), .ReadData1(rd1_b), .ReadData2(rd2_b),
        .WriteEn0(we0), .WriteAddr0(wa0), .WriteData0(wd0),
        .WriteEn1(we1), .WriteAddr1(wa1), .WriteData1(wd1),
        .Clear(clear), .Busy(busy_b)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .BYPASS(0), .ZERO_REG(1)) u_dut_nob (
        .clock(clk), .Reset_n(rst_n),
        .ReadAddr1(ra1), .ReadAddr2(ra2), .ReadData1(rd1_n), .ReadData2(rd2_n),
        .WriteEn0(we0), .WriteAddr0(wa0), .WriteData0(wd0),
        .WriteEn1(we1), .WriteAddr1(wa1), .WriteData1(wd1),
        .Clear(clear), .Busy(busy_n)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_writes();
        we0 = 1'b0; we1 = 1'b0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    endtask

    // Pulses Clear for one edge, then counts sampled cycles with Busy high.
    task automatic run_clear(output int n);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        n = 0;
        while (busy_b === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; ra1 = '0; ra2 = '0;
        idle_writes();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        ra1 = 5'd5; ra2 = 5'd31;
        #1;
        check("reset_busy", {31'd0, busy_b}, 32'd0);
        check("reset_rd1", rd1_b, 32'd0);
        check("reset_rd2", rd2_n, 32'd0);

        // Write port 1 to addr 5: bypass build sees it immediately, the other after the edge
        @(negedge clk);
        we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEADBEEF; ra1 = 5'd5;
        #1;
        check("wr5_bypass_same", rd1_b, 32'hDEADBEEF);
        check("wr5_nobyp_same", rd1_n, 32'h0);
        @(negedge clk);
        idle_writes();
        #1;
        check("wr5_bypass_next", rd1_b, 32'hDEADBEEF);
        check("wr5_nobyp_next", rd1_n, 32'hDEADBEEF);

        // Zero register: write dropped and never bypassed
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h12345678; ra2 = 5'd0;
        #1;
        check("zero_bypass", rd2_b, 32'h0);
        @(negedge clk);
        idle_writes();
        #1;
        check("zero_after_b", rd2_b, 32'h0);
        check("zero_after_n", rd2_n, 32'h0);

        // Collision on addr 7: port 1 wins
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h1111;
        we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h2222;
        ra1 = 5'd7; ra2 = 5'd7;
        #1;
        check("coll_bypass", rd1_b, 32'h2222);
        check("coll_nobyp", rd2_n, 32'h0);
        @(negedge clk);
        idle_writes();
        #1;
        check("coll_store_b", rd2_b, 32'h2222);
        check("coll_store_n", rd1_n, 32'h2222);

        // Bypass off: same-cycle read of addr 3 returns old content
        @(negedge clk);
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hA5A5; ra1 = 5'd3; ra2 = 5'd3;
        #1;
        check("nob_old", rd1_n, 32'h0);
        check("byp_new", rd2_b, 32'hA5A5);
        @(negedge clk);
        idle_writes();
        #1;
        check("nob_next", rd1_n, 32'hA5A5);

        // Asynchronous reset mid-cycle after writes
        @(negedge clk);
        ra1 = 5'd5; ra2 = 5'd7;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rd1", rd1_b, 32'h0);
        check("async_rd2", rd2_n, 32'h0);
        check("async_busy", {31'd0, busy_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill all entries, two per cycle
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            we0 = 1'b1; wa0 = 5'(i);      wd0 = 32'hC0DE0000 + 32'(i);
            we1 = 1'b1; wa1 = 5'(i + 16); wd1 = 32'hC0DE0000 + 32'(i + 16);
        end
        @(negedge clk);
        idle_writes();
        ra1 = 5'd31; ra2 = 5'd0;
        #1;
        check("fill_31", rd1_b, 32'hC0DE001F);
        check("fill_0", rd2_n, 32'h0);
        ra1 = 5'd17;
        #1;
        check("fill_17", rd1_n, 32'hC0DE0011);

        // Soft clear with a write attempt held for the whole sweep
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        we1 = 1'b1; wa1 = 5'd31; wd1 = 32'hFFFFFFFF; ra1 = 5'd31;
        #1;
        check("sweep_busy", {31'd0, busy_b}, 32'd1);
        check("sweep_no_bypass", rd1_b, 32'hC0DE001F);
        cycles = 0;
        while (busy_b === 1'b1 && cycles < 100) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        idle_writes();
        check("sweep_len", 32'(cycles), 32'd32);
        check("sweep_busy_n", {31'd0, busy_n}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i); ra2 = 5'(31 - i);
            #1;
            check("cleared_b", rd1_b, 32'h0);
            check("cleared_n", rd2_n, 32'h0);
        end

        // Reset in the middle of a sweep abandons it
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check("mid_busy_pre", {31'd0, busy_b}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_busy_b", {31'd0, busy_b}, 32'd0);
        check("mid_busy_n", {31'd0, busy_n}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_clear(cycles);
        check("resweep_len", 32'(cycles), 32'd32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule : tb_regfile_mp
`default_nettype wire
